// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: ALUCtrl codes, FSM encoding
// and a helper that classifies shift operations.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle evaluator for logic, add/sub and slt; flags signed overflow
// and unknown codes. Shift codes are legal here but produce zero.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_illegal
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;

    assign w_sum     = i_a + i_b;
    assign w_diff    = i_a - i_b;
    assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    // The sign of the difference is inverted exactly when the subtraction overflows.
    assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_ctrl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_ADD: begin
                o_result   = w_sum;
                o_overflow = w_add_ovf;
            end
            ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = w_sub_ovf;
            end
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_SLL, ALU_SRL, ALU_SRA: o_result = '0;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops via alu_comb_core, shifts on an
// iterative step shifter that holds Busy/Stall until the result is ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [4:0]       Shamt,
    input  logic             Flush,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             IllegalOp,
    output logic             Done,
    output logic             Busy,
    output logic             Stall
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    alu_state_t       r_state;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;
    logic             r_done;

    logic [WIDTH-1:0] w_core_res;
    logic             w_core_ovf;
    logic             w_core_ill;
    logic [WIDTH-1:0] w_idle_res;
    logic             w_start_shift;
    logic [4:0]       w_k;
    logic [4:0]       w_cnt_next;
    logic [WIDTH-1:0] w_shifted;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_ctrl     (ALUCtrl),
        .i_a        (SrcA),
        .i_b        (SrcB),
        .o_result   (w_core_res),
        .o_overflow (w_core_ovf),
        .o_illegal  (w_core_ill)
    );

    // A shift by zero completes in one cycle and simply passes SrcB through.
    assign w_idle_res    = is_shift(ALUCtrl) ? SrcB : w_core_res;
    assign w_start_shift = Start && is_shift(ALUCtrl) && (Shamt != 5'd0);

    assign w_k        = (r_cnt < STEP) ? r_cnt : STEP;
    assign w_cnt_next = r_cnt - w_k;

    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            ALU_SLL: w_shifted = r_acc << w_k;
            ALU_SRL: w_shifted = r_acc >> w_k;
            ALU_SRA: w_shifted = $signed(r_acc) >>> w_k;
            default: w_shifted = r_acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= '0;
            r_op       <= ALU_AND;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
            r_done     <= 1'b0;
        end else if (Flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_shift) begin
                        r_acc   <= SrcB;
                        r_cnt   <= Shamt;
                        r_op    <= ALUCtrl;
                        r_state <= ST_SHIFT;
                    end else if (Start) begin
                        r_result   <= w_idle_res;
                        r_zero     <= (w_idle_res == '0);
                        r_overflow <= w_core_ovf;
                        r_illegal  <= w_core_ill;
                        r_done     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == 5'd0) begin
                        r_result   <= w_shifted;
                        r_zero     <= (w_shifted == '0);
                        r_overflow <= 1'b0;
                        r_illegal  <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Result    = r_result;
    assign Zero      = r_zero;
    assign Overflow  = r_overflow;
    assign IllegalOp = r_illegal;
    assign Done      = r_done;
    assign Busy      = (r_state == ST_SHIFT);
    assign Stall     = Busy || ((r_state == ST_IDLE) && w_start_shift);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with one SHIFT_STEP=1 and one
// SHIFT_STEP=4 instance sharing operands, flush and reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start4;
    logic [3:0]  ctrl;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        flush;

    logic [31:0] res1, res4;
    logic        zero1, zero4, ovf1, ovf4, ill1, ill4;
    logic        done1, done4, busy1, busy4, stall1, stall4;

    int sel;
    logic [31:0] w_res;
    logic        w_zero, w_ovf, w_ill, w_done, w_busy, w_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(start1), .ALUCtrl(ctrl), .SrcA(src_a),
        .SrcB(src_b), .Shamt(shamt), .Flush(flush), .Result(res1), .Zero(zero1),
        .Overflow(ovf1), .IllegalOp(ill1), .Done(done1), .Busy(busy1), .Stall(stall1)
    );

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Start(start4), .ALUCtrl(ctrl), .SrcA(src_a),
        .SrcB(src_b), .Shamt(shamt), .Flush(flush), .Result(res4), .Zero(zero4),
        .Overflow(ovf4), .IllegalOp(ill4), .Done(done4), .Busy(busy4), .Stall(stall4)
    );

    assign w_res   = (sel != 0) ? res4   : res1;
    assign w_zero  = (sel != 0) ? zero4  : zero1;
    assign w_ovf   = (sel != 0) ? ovf4   : ovf1;
    assign w_ill   = (sel != 0) ? ill4   : ill1;
    assign w_done  = (sel != 0) ? done4  : done1;
    assign w_busy  = (sel != 0) ? busy4  : busy1;
    assign w_stall = (sel != 0) ? stall4 : stall1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called mid-cycle (after a negedge); that cycle is cycle 0 of the op.
    task automatic run_op(input int which, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          output int done_cyc, output int busy_n, output int stall_n);
        sel   = which;
        ctrl  = c;
        src_a = a;
        src_b = b;
        shamt = sh;
        if (which != 0) start4 = 1'b1;
        else            start1 = 1'b1;
        done_cyc = -1;
        busy_n   = 0;
        stall_n  = 0;
        #1;
        if (w_stall) stall_n++;
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            start4 = 1'b0;
            #1;
            if (w_busy)  busy_n++;
            if (w_stall) stall_n++;
            if (w_done)  done_cyc = cyc;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (w_done) n++;
        end
    endtask

    initial begin
        int dc, bn, sn, nd;
        logic [31:0] prev;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        ctrl   = 4'b0000;
        src_a  = '0;
        src_b  = '0;
        shamt  = '0;
        flush  = 1'b0;
        sel    = 0;

        repeat (3) @(negedge clk);
        chk("rst_result1", res1, 32'h0);
        chk("rst_flags1", {28'h0, zero1, ovf1, ill1, done1}, 32'h0);
        chk("rst_busy_stall1", {30'h0, busy1, stall1}, 32'h0);
        chk("rst_result4", res4, 32'h0);
        chk("rst_flags4", {27'h0, zero4, ovf4, ill4, done4, busy4}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, dc, bn, sn);
        chk("add_ovf_done_cyc", dc, 1);
        chk("add_ovf_result", w_res, 32'h8000_0000);
        chk("add_ovf_overflow", {31'h0, w_ovf}, 1);
        chk("add_ovf_zero", {31'h0, w_zero}, 0);
        chk("add_ovf_stall", sn, 0);

        run_op(0, 4'b0110, 32'd5, 32'd5, 5'd0, dc, bn, sn);
        chk("sub_done_cyc", dc, 1);
        chk("sub_result", w_res, 32'h0);
        chk("sub_zero", {31'h0, w_zero}, 1);
        chk("sub_overflow", {31'h0, w_ovf}, 0);

        run_op(0, 4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0, dc, bn, sn);
        chk("slt_neg_lt_pos", w_res, 32'h1);
        run_op(0, 4'b0111, 32'h0000_0001, 32'h8000_0000, 5'd0, dc, bn, sn);
        chk("slt_pos_lt_neg", w_res, 32'h0);
        chk("slt_ovf_flag", {31'h0, w_ovf}, 0);

        run_op(0, 4'b0100, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, dc, bn, sn);
        chk("nor_result", w_res, 32'h0F0F_FF00);

        run_op(0, 4'b1010, 32'h0, 32'h8000_0000, 5'd31, dc, bn, sn);
        chk("sra31_done_cyc", dc, 32);
        chk("sra31_busy_cycles", bn, 31);
        chk("sra31_stall_cycles", sn, 32);
        chk("sra31_result", w_res, 32'hFFFF_FFFF);

        run_op(0, 4'b1001, 32'h0, 32'h8000_0000, 5'd31, dc, bn, sn);
        chk("srl31_done_cyc", dc, 32);
        chk("srl31_result", w_res, 32'h0000_0001);

        run_op(1, 4'b1000, 32'h0, 32'h0000_0001, 5'd7, dc, bn, sn);
        chk("sll7_s4_done_cyc", dc, 3);
        chk("sll7_s4_busy_cycles", bn, 2);
        chk("sll7_s4_stall_cycles", sn, 3);
        chk("sll7_s4_result", w_res, 32'h0000_0080);

        run_op(1, 4'b1000, 32'h0, 32'h0000_1234, 5'd0, dc, bn, sn);
        chk("sll0_done_cyc", dc, 1);
        chk("sll0_result", w_res, 32'h0000_1234);
        chk("sll0_stall", sn, 0);
        run_op(1, 4'b0010, 32'd2, 32'd3, 5'd0, dc, bn, sn);
        chk("b2b_add_done_cyc", dc, 1);
        chk("b2b_add_result", w_res, 32'd5);
        @(negedge clk);
        #1;
        chk("b2b_done_single", {31'h0, w_done}, 0);
        chk("b2b_result_hold", w_res, 32'd5);

        sel  = 0;
        prev = res1;
        ctrl = 4'b1000; src_b = 32'h1; shamt = 5'd10; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        start1 = 1'b1; ctrl = 4'b0010; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        flush = 1'b0; start1 = 1'b0;
        #1;
        chk("flush_busy_after", {31'h0, w_busy}, 0);
        count_dones(15, nd);
        chk("flush_no_done", nd, 0);
        chk("flush_result_hold", w_res, prev);

        run_op(0, 4'b1111, 32'd5, 32'd5, 5'd0, dc, bn, sn);
        chk("illegal_done_cyc", dc, 1);
        chk("illegal_flag", {31'h0, w_ill}, 1);
        chk("illegal_result", w_res, 32'h0);
        run_op(0, 4'b0010, 32'd1, 32'd2, 5'd0, dc, bn, sn);
        chk("add_after_illegal", w_res, 32'd3);
        chk("illegal_flag_clear", {31'h0, w_ill}, 0);

        ctrl = 4'b1000; src_b = 32'h1; shamt = 5'd20; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_reset_busy", {31'h0, w_busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", w_res, 32'h0);
        chk("midrst_flags", {27'h0, w_zero, w_ovf, w_ill, w_done, w_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(30, nd);
        chk("midrst_no_done", nd, 0);
        run_op(0, 4'b0010, 32'h10, 32'h20, 5'd0, dc, bn, sn);
        chk("post_rst_add_done_cyc", dc, 1);
        chk("post_rst_add_result", w_res, 32'h30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU for the MIPS pipeline; consumes the 4-bit ALUCtrl code produced by the control unit's ALU decoder.
- Logic, arithmetic and compare ops complete in 1 cycle.
- Shifts (sll/srl/sra) run on an iterative shifter to save area, and raise Busy so the hazard unit stalls IF/ID/EX.
- Results are registered and qualified by a one-cycle Done pulse toward the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHIFT_STEP, 1, maximum bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  operation valid, sampled at the rising edge.
- ALUCtrl  in  4  operation code.
- SrcA  in  WIDTH  operand A (rs).
- SrcB  in  WIDTH  operand B (rt or immediate); this is the value that is shifted.
- Shamt  in  5  shift amount.
- Flush  in  1  synchronous abort.
- Result  out  WIDTH  registered result.
- Zero  out  1  registered; Result == 0.
- Overflow  out  1  registered; signed overflow on add/sub.
- IllegalOp  out  1  registered; unknown code flag, valid with Done.
- Done  out  1  one-cycle pulse; Result/Zero/Overflow/IllegalOp are valid.
- Busy  out  1  shift in progress.
- Stall  out  1  combinational pipeline stall request.

Behaviour:
- Reset: asynchronous, active-low (rst_n = 0). Outputs go to Result=0, Zero=0, Overflow=0, IllegalOp=0, Done=0, Busy=0. State goes to IDLE, shift counter to 0. Reset mid-shift discards the operation and produces no Done.
- ALUCtrl codes:
  - 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0110 sub, 0111 slt.
  - 1000 sll, 1001 srl, 1010 sra.
  - All other codes are illegal.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - Overflow = signed overflow for add/sub only; 0 for every other op.
  - slt returns 1 if SrcA < SrcB signed, else 0. The result must be correct even when SrcA - SrcB overflows.
- FSM states: IDLE, SHIFT.
- IDLE with Start=1 and Flush=0:
  - Non-shift op, or a shift with Shamt=0: result registered at this edge; Done=1 in the next cycle; stay in IDLE. Latency is 1.
  - Shift with Shamt=n>0: load accumulator from SrcB and counter from n, go to SHIFT. Operands and ALUCtrl are latched, so the inputs may change afterwards.
  - Illegal code: Result=0, IllegalOp=1, Done=1 next cycle (latency 1).
- SHIFT, each edge:
  - Shift the accumulator by k = min(counter, SHIFT_STEP); counter -= k.
  - srl fills with 0; sra fills with the sign bit.
  - On the edge where the counter reaches 0: register Result, Done=1 next cycle, return to IDLE.
  - With m = ceil(n/SHIFT_STEP), Busy is high in cycles 1..m and Done is high in cycle m+1 (cycle 0 = Start cycle).
- Start while in SHIFT is ignored. The upstream stage must hold the instruction via Stall.
- Busy = (state == SHIFT).
- Stall = Busy OR (IDLE AND Start AND shift op AND Shamt != 0). Stall is low in the Done cycle.
- Done is high for exactly 1 cycle per accepted op. Result/Zero/Overflow/IllegalOp hold their values until the next Done.
- A new Start is accepted in the Done cycle (back-to-back ops are allowed).
- Flush (highest priority after reset):
  - At the edge it is sampled: state to IDLE, counter cleared, no Done is produced for the aborted op, and a Start in the same cycle is dropped.
  - Result and the flags keep their previous values.
- Zero is computed from the value being registered into Result.

Decomposition:
- Shared package alu_pkg:
  - localparams for all ALUCtrl codes (ALU_AND ... ALU_SRA);
  - the state encoding (IDLE=0, SHIFT=1);
  - an is_shift function.
- One sub-module: alu_comb_core, a purely combinational single-cycle op evaluator (and/or/xor/nor/add/sub/slt, Overflow, illegal detect).
- The FSM, counter and step shifter stay in alu_exec_unit.

Test Plan:
- Reset: assert rst_n=0 mid-shift (sll, Shamt=20, cycle 5) -> all outputs 0, no Done after release; the next add executes normally.
- add 0x7FFFFFFF + 0x00000001 -> Done at cycle 1, Result=0x80000000, Overflow=1, Zero=0. sub 5-5 -> Result=0, Zero=1, Overflow=0.
- slt with SrcA=0x80000000, SrcB=0x00000001 -> Result=1. Swap the operands -> Result=0 (overflow case correct).
- SHIFT_STEP=1, sra SrcB=0x80000000, Shamt=31 -> Busy cycles 1..31, Stall high cycles 0..31, Done at cycle 32, Result=0xFFFFFFFF. srl of the same -> 0x00000001.
- SHIFT_STEP=4, sll SrcB=1, Shamt=7 -> Done at cycle 3, Result=0x80. Shamt=0 -> Done at cycle 1, Result=SrcB. Back-to-back Start in the Done cycle is accepted.
- Flush at cycle 3 of sll Shamt=10 -> no Done, Result unchanged, Busy=0 next cycle. ALUCtrl=1111 -> Done cycle 1, IllegalOp=1, Result=0.
